// File: rtl/router_fifo_reader.sv
// Destination-side reader for one router output FIFO: pops bytes, reframes header/payload/parity,
// streams them to a valid/ready sink and reports per-packet status. Option: ROUTER_RX_PARITY_CHECK_EN.
module router_fifo_reader #(
  parameter int unsigned TIMEOUT_CYC = 30,
  parameter int unsigned TO_W        = 6,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             fifo_vld,
  input  logic [7:0]       fifo_data,
  output logic             read_enb,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_sop,
  output logic             rx_eop,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic             err_parity,
  output logic             err_timeout,
  output logic [5:0]       pkt_len,
  output logic [1:0]       pkt_addr,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic [1:0] {StIdle, StPayload, StParity} state_e;

  state_e           state_q;
  logic [9:0]       skid_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       occ_q, occ_d;
  logic             rd_pending_q;
  logic             en_q;
  logic [5:0]       remain_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             pkt_done_q, pkt_err_q, err_timeout_q;
  logic [5:0]       pkt_len_q;
  logic [1:0]       pkt_addr_q;
  logic [CNT_W-1:0] pkt_count_q;

  logic       pop, arrive, tick, abort, parity_ok;
  logic [2:0] fill;
  logic [9:0] push_entry;
  logic [9:0] head;

  assign rx_valid   = (occ_q != 2'd0);
  assign pop        = rx_valid & rx_ready;
  assign arrive     = rd_pending_q & ~soft_reset;
  // Projected skid fill once the in-flight byte lands; keeps room for it.
  assign fill       = 3'(occ_q) + 3'(rd_pending_q) - 3'(pop);
  assign read_enb   = en_q & fifo_vld & ~soft_reset & (fill < 3'd2);
  assign push_entry = {state_q == StParity, state_q == StIdle, fifo_data};

  assign head    = skid_q[rd_ptr_q];
  assign rx_data = head[7:0];
  assign rx_sop  = head[8];
  assign rx_eop  = head[9];

  // Backpressure stalls (fifo_vld high) never advance the timeout.
  assign tick  = (state_q != StIdle) & ~arrive & ~fifo_vld;
  assign abort = tick & (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

`ifdef ROUTER_RX_PARITY_CHECK_EN
  logic [7:0] parity_q;
  logic       err_parity_q;
  assign parity_ok  = (fifo_data == parity_q);
  assign err_parity = err_parity_q;
`else
  assign parity_ok  = 1'b1;
  assign err_parity = 1'b0;
`endif

  always_comb begin
    occ_d = occ_q;
    if (arrive && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!arrive && pop) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      skid_q[0]    <= '0;
      skid_q[1]    <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
      rd_pending_q <= 1'b0;
      en_q         <= 1'b0;
    end else begin
      en_q <= 1'b1;
      if (soft_reset) begin
        rd_ptr_q     <= 1'b0;
        wr_ptr_q     <= 1'b0;
        occ_q        <= 2'd0;
        rd_pending_q <= 1'b0;
      end else begin
        rd_pending_q <= read_enb & fifo_vld;
        occ_q        <= occ_d;
        if (arrive) begin
          skid_q[wr_ptr_q] <= push_entry;
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      remain_q      <= 6'd0;
      to_cnt_q      <= '0;
      pkt_done_q    <= 1'b0;
      pkt_err_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      pkt_len_q     <= 6'd0;
      pkt_addr_q    <= 2'd0;
      pkt_count_q   <= '0;
`ifdef ROUTER_RX_PARITY_CHECK_EN
      parity_q      <= 8'd0;
      err_parity_q  <= 1'b0;
`endif
    end else begin
      pkt_done_q <= 1'b0;
      pkt_err_q  <= 1'b0;
      if (soft_reset) begin
        state_q  <= StIdle;
        to_cnt_q <= '0;
      end else if (arrive) begin
        to_cnt_q <= '0;
        unique case (state_q)
          StIdle: begin
            pkt_len_q  <= fifo_data[7:2];
            pkt_addr_q <= fifo_data[1:0];
            remain_q   <= fifo_data[7:2];
`ifdef ROUTER_RX_PARITY_CHECK_EN
            parity_q   <= fifo_data;
`endif
            state_q    <= (fifo_data[7:2] == 6'd0) ? StParity : StPayload;
          end
          StPayload: begin
`ifdef ROUTER_RX_PARITY_CHECK_EN
            parity_q <= parity_q ^ fifo_data;
`endif
            remain_q <= remain_q - 6'd1;
            if (remain_q == 6'd1) begin
              state_q <= StParity;
            end
          end
          StParity: begin
            state_q       <= StIdle;
            err_timeout_q <= 1'b0;
            if (parity_ok) begin
              pkt_done_q <= 1'b1;
              if (pkt_count_q != '1) begin
                pkt_count_q <= pkt_count_q + CNT_W'(1);
              end
`ifdef ROUTER_RX_PARITY_CHECK_EN
              err_parity_q <= 1'b0;
            end else begin
              pkt_err_q    <= 1'b1;
              err_parity_q <= 1'b1;
`endif
            end
          end
          default: state_q <= StIdle;
        endcase
      end else if (abort) begin
        state_q       <= StIdle;
        to_cnt_q      <= '0;
        pkt_err_q     <= 1'b1;
        err_timeout_q <= 1'b1;
`ifdef ROUTER_RX_PARITY_CHECK_EN
        err_parity_q  <= 1'b0;
`endif
      end else if (tick) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end
  end

  assign pkt_done    = pkt_done_q;
  assign pkt_err     = pkt_err_q;
  assign err_timeout = err_timeout_q;
  assign pkt_len     = pkt_len_q;
  assign pkt_addr    = pkt_addr_q;
  assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_router_fifo_reader.sv
// Directed bench for router_fifo_reader: a registered-read FIFO model feeds the reader and a
// negedge monitor captures the sink stream and status pulses.
module tb_router_fifo_reader;

  typedef logic [7:0] bq_t[$];

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        soft_reset = 1'b0;
  logic        fifo_vld;
  logic [7:0]  fifo_data;
  logic        read_enb;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b1;
  logic        rx_sop, rx_eop;
  logic        pkt_done, pkt_err, err_parity, err_timeout;
  logic [5:0]  pkt_len;
  logic [1:0]  pkt_addr;
  logic [15:0] pkt_count;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int cyc      = 0;
  int exp_count = 0;

  logic [7:0] fq[$];
  logic [9:0] rxq[$];
  int         rxt[$];
  logic [9:0] eq[$];

  router_fifo_reader #(
    .TIMEOUT_CYC(30),
    .TO_W       (6),
    .CNT_W      (16)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .fifo_vld   (fifo_vld),
    .fifo_data  (fifo_data),
    .read_enb   (read_enb),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_sop     (rx_sop),
    .rx_eop     (rx_eop),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err),
    .err_parity (err_parity),
    .err_timeout(err_timeout),
    .pkt_len    (pkt_len),
    .pkt_addr   (pkt_addr),
    .pkt_count  (pkt_count)
  );

  always #5 clock = ~clock;

  // Router FIFO model: registered not-empty and registered read data.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fq.delete();
      fifo_vld  <= 1'b0;
      fifo_data <= 8'd0;
    end else if (soft_reset) begin
      fq.delete();
      fifo_vld <= 1'b0;
    end else begin
      if (read_enb && fifo_vld) begin
        fifo_data <= fq[0];
        void'(fq.pop_front());
      end
      fifo_vld <= (fq.size() != 0);
    end
  end

  always @(negedge clock) begin
    cyc++;
    if (rx_valid && rx_ready) begin
      rxq.push_back({rx_eop, rx_sop, rx_data});
      rxt.push_back(cyc);
    end
    if (pkt_done) done_cnt++;
    if (pkt_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_pkt(input bq_t b);
    eq.delete();
    rxq.delete();
    rxt.delete();
    foreach (b[i]) begin
      fq.push_back(b[i]);
      eq.push_back({(i == b.size() - 1) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, b[i]});
    end
  endtask

  task automatic wait_status(input string tag, input int budget);
    int  base;
    bit  got;
    base = done_cnt + err_cnt;
    got  = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clock);
      if (done_cnt + err_cnt > base) got = 1;
    end
    check({tag, "_status_seen"}, 32'(got), 32'd1);
    tick(3);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, rxq.size(), eq.size());
    foreach (eq[i]) begin
      if (i < rxq.size()) check($sformatf("%s_b%0d", tag, i), 32'(rxq[i]), 32'(eq[i]));
    end
  endtask

  initial begin
    int  d0, e0, n;
    bit  seen;
    bq_t p;

    // Reset state
    tick(2);
    check("rst_outs", {read_enb, rx_valid, rx_sop, rx_eop, rx_data, pkt_done, pkt_err,
                       err_parity, err_timeout, pkt_len, pkt_addr}, 32'd0);
    check("rst_count", pkt_count, 32'd0);
    resetn = 1'b1;
    tick(2);

    // 1: good packet, back-to-back delivery
    d0 = done_cnt;
    p = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    push_pkt(p);
    wait_status("t1", 40);
    check_stream("t1");
    if (rxt.size() == 5) check("t1_b2b", rxt[4] - rxt[0], 32'd4);
    check("t1_done", done_cnt - d0, 32'd1);
    check("t1_len", pkt_len, 32'd3);
    check("t1_addr", pkt_addr, 32'd1);
    exp_count = 1;
    check("t1_count", pkt_count, exp_count);
    check("t1_eflags", {err_parity, err_timeout}, 32'd0);

    // 2: same packet, bad parity byte
    d0 = done_cnt;
    e0 = err_cnt;
    p = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0E};
    push_pkt(p);
    wait_status("t2", 40);
    check_stream("t2");
`ifdef ROUTER_RX_PARITY_CHECK_EN
    check("t2_err", err_cnt - e0, 32'd1);
    check("t2_done", done_cnt - d0, 32'd0);
    check("t2_eparity", err_parity, 32'd1);
`else
    check("t2_err", err_cnt - e0, 32'd0);
    check("t2_done", done_cnt - d0, 32'd1);
    check("t2_eparity", err_parity, 32'd0);
    exp_count++;
`endif
    check("t2_etimeout", err_timeout, 32'd0);
    check("t2_count", pkt_count, exp_count);

    // 3: 10-byte payload with a 6-cycle sink stall
    d0 = done_cnt;
    e0 = err_cnt;
    p = '{8'h28, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h23};
    push_pkt(p);
    tick(4);
    rx_ready = 1'b0;
    tick(5);
    @(negedge clock);
    check("t3_stall_rdenb", read_enb, 32'd0);
    check("t3_stall_valid", rx_valid, 32'd1);
    tick(1);
    rx_ready = 1'b1;
    wait_status("t3", 60);
    check_stream("t3");
    check("t3_done", done_cnt - d0, 32'd1);
    check("t3_noerr", err_cnt - e0, 32'd0);
    check("t3_len", pkt_len, 32'd10);
    exp_count++;
    check("t3_count", pkt_count, exp_count);

    // 4: FIFO runs dry after 2 of 5 payload bytes
    e0 = err_cnt;
    p = '{8'h15, 8'h01, 8'h02};
    push_pkt(p);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (fifo_vld) seen = 1;
    end
    check("t4_vld_up", 32'(seen), 32'd1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (!fifo_vld) seen = 1;
    end
    check("t4_vld_down", 32'(seen), 32'd1);
    n = 0;
    while (n < 40 && !pkt_err) begin
      @(negedge clock);
      n++;
    end
    check("t4_to_latency", n, 32'd31);
    check("t4_etimeout", err_timeout, 32'd1);
    check("t4_eparity", err_parity, 32'd0);
    tick(2);
    check("t4_err", err_cnt - e0, 32'd1);
    check("t4_count", pkt_count, exp_count);
    d0 = done_cnt;
    p = '{8'h02, 8'h02};
    push_pkt(p);
    wait_status("t4b", 40);
    check_stream("t4b");
    check("t4b_done", done_cnt - d0, 32'd1);
    check("t4b_len", pkt_len, 32'd0);
    check("t4b_addr", pkt_addr, 32'd2);
    check("t4b_etimeout", err_timeout, 32'd0);
    exp_count++;
    check("t4b_count", pkt_count, exp_count);

    // 5: soft_reset with a full skid
    d0 = done_cnt;
    e0 = err_cnt;
    rx_ready = 1'b0;
    p = '{8'h15, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h55};
    push_pkt(p);
    tick(8);
    check("t5_pre_valid", rx_valid, 32'd1);
    soft_reset = 1'b1;
    @(negedge clock);
    check("t5_sr_rdenb", read_enb, 32'd0);
    tick(1);
    soft_reset = 1'b0;
    @(negedge clock);
    check("t5_post_valid", rx_valid, 32'd0);
    tick(5);
    check("t5_nopulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);
    check("t5_count", pkt_count, exp_count);
    check("t5_len", pkt_len, 32'd5);
    rx_ready = 1'b1;
    p = '{8'h05, 8'hAA, 8'hAF};
    push_pkt(p);
    wait_status("t5b", 40);
    check_stream("t5b");
    check("t5b_done", done_cnt - d0, 32'd1);
    check("t5b_len", pkt_len, 32'd1);
    exp_count++;
    check("t5b_count", pkt_count, exp_count);

    // 6: asynchronous reset mid-payload
    p = '{8'h15, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h11};
    push_pkt(p);
    tick(4);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_outs", {read_enb, rx_valid, rx_sop, rx_eop, rx_data, pkt_done, pkt_err,
                          err_parity, err_timeout, pkt_len, pkt_addr}, 32'd0);
    check("t6_rst_count", pkt_count, 32'd0);
    tick(2);
    resetn = 1'b1;
    tick(2);
    d0 = done_cnt;
    p = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    push_pkt(p);
    wait_status("t6", 40);
    check_stream("t6");
    check("t6_done", done_cnt - d0, 32'd1);
    check("t6_count", pkt_count, 32'd1);
    check("t6_len", pkt_len, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
